// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared cpu types for the memory stage
package mem_stage_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {SEQ = 2'b00, BEQ = 2'b01, JMP = 2'b10, JR = 2'b11} pcsrc_t;
  typedef enum logic [1:0] {ALU = 2'b00, LOAD = 2'b01, NPC = 2'b10} wdatsel_t;
  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-memory request bus with hit handshake
//   dmemREN/dmemWEN/dmemaddr/dmemstore : request from the controller
//   dhit/dmemload                      : completion and load data from memory
interface mem_stage_ctrl_if #(parameter int WORD_W = 32);
  logic dmemREN;
  logic dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic dhit;
  logic [WORD_W-1:0] dmemload;
  modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore, input dhit, dmemload);
  modport slave (input dmemREN, dmemWEN, dmemaddr, dmemstore, output dhit, dmemload);
endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// mem_stage_ctrl_mem_wb_reg: MEM/WB pipeline register with enable and bubble insertion
//   en loads all fields; otherwise fields hold and regwr is cleared to a bubble
module mem_stage_ctrl_mem_wb_reg import mem_stage_ctrl_pkg::*; #(
  parameter int W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic regwr_in,
  input  regbits_t wsel_in,
  input  logic [W-1:0] wdat_in,
  output logic regwr,
  output regbits_t wsel,
  output logic [W-1:0] wdat
);
  always_ff @(posedge clk) begin
    if (rst) begin
      regwr <= 1'b0;
      wsel <= '0;
      wdat <= '0;
    end else if (en) begin
      regwr <= regwr_in;
      wsel <= wsel_in;
      wdat <= wdat_in;
    end else begin
      regwr <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller - dmem handshake, stall, redirect, MEM/WB register
//   in : EX/MEM latch fields (*_MEM), dmem.dhit/dmemload
//   out: dmem request, mem_stall, redirect/redirect_addr, *_WB, mem_err, stall_cnt
module mem_stage_ctrl import mem_stage_ctrl_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic CLK,
  input  logic RST,
  input  logic valid_MEM,
  input  logic RegWr_MEM,
  input  regbits_t Wsel_MEM,
  input  logic memtoReg_MEM,
  input  logic memWr_MEM,
  input  logic [1:0] WdatSel_MEM,
  input  logic [1:0] PC_Src_MEM,
  input  logic zero_MEM,
  input  logic [WORD_W-1:0] Output_Port_MEM,
  input  logic [WORD_W-1:0] store_MEM,
  input  logic [WORD_W-1:0] busA_MEM,
  input  logic [WORD_W-1:0] branch_addr_MEM,
  input  logic [WORD_W-1:0] jump_addr_MEM,
  input  logic [WORD_W-1:0] npc_MEM,
  mem_stage_ctrl_if.master dmem,
  output logic mem_stall,
  output logic redirect,
  output logic [WORD_W-1:0] redirect_addr,
  output logic RegWr_WB,
  output regbits_t Wsel_WB,
  output logic [WORD_W-1:0] wdat_WB,
  output logic mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_WAIT = WAIT;
  localparam int WC_W = $clog2(TIMEOUT + 1);
  logic [0:0] state;
  logic [WC_W-1:0] wait_cnt;
  logic cap_ren, cap_wen;
  logic [WORD_W-1:0] cap_addr, cap_store, wdat_next;
  logic memop, idle_req, in_wait, timeout, wait_req, complete;
  pcsrc_t pc_src;
  wdatsel_t wsel_src;
  // every combinational output is forced low while RST is held
  always_comb begin
    memop = valid_MEM & (memtoReg_MEM | memWr_MEM);
    idle_req = !RST & (state == S_IDLE) & memop;
    in_wait = !RST & (state == S_WAIT);
    // the TIMEOUT-th WAIT cycle without a hit abandons the request
    timeout = in_wait & !dmem.dhit & (wait_cnt == WC_W'(TIMEOUT - 1));
    wait_req = in_wait & !timeout;
    dmem.dmemREN = idle_req ? memtoReg_MEM : wait_req & cap_ren;
    dmem.dmemWEN = idle_req ? memWr_MEM & !memtoReg_MEM : wait_req & cap_wen;
    dmem.dmemaddr = idle_req ? Output_Port_MEM : wait_req ? cap_addr : '0;
    dmem.dmemstore = idle_req ? store_MEM : wait_req ? cap_store : '0;
    mem_stall = idle_req ? !dmem.dhit : wait_req & !dmem.dhit;
    complete = !RST & valid_MEM & !mem_stall;
    pc_src = pcsrc_t'(PC_Src_MEM);
    redirect = complete & ((pc_src == BEQ) ? zero_MEM : (pc_src != SEQ));
    redirect_addr = !redirect ? '0 : (pc_src == JR) ? busA_MEM :
                    (pc_src == JMP) ? jump_addr_MEM : branch_addr_MEM;
    wsel_src = wdatsel_t'(WdatSel_MEM);
    wdat_next = (wsel_src == LOAD) ? dmem.dmemload : (wsel_src == NPC) ? npc_MEM : Output_Port_MEM;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      wait_cnt <= '0;
      cap_ren <= 1'b0;
      cap_wen <= 1'b0;
      cap_addr <= '0;
      cap_store <= '0;
      mem_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(mem_stall & ~&stall_cnt);
      if (timeout) mem_err <= 1'b1;
      if (state == S_IDLE) begin
        wait_cnt <= '0;
        if (memop && !dmem.dhit) begin
          state <= S_WAIT;
          cap_ren <= memtoReg_MEM;
          cap_wen <= memWr_MEM & !memtoReg_MEM;
          cap_addr <= Output_Port_MEM;
          cap_store <= store_MEM;
        end
      end else if (dmem.dhit || timeout) begin
        state <= S_IDLE;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
  mem_stage_ctrl_mem_wb_reg #(.W(WORD_W)) u_mem_wb (
    .clk(CLK),
    .rst(RST),
    .en(complete),
    .regwr_in(RegWr_MEM & !timeout),
    .wsel_in(Wsel_MEM),
    .wdat_in(wdat_next),
    .regwr(RegWr_WB),
    .wsel(Wsel_WB),
    .wdat(wdat_WB)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
  logic CLK = 1'b0;
  logic RST;
  logic valid_MEM, RegWr_MEM, memtoReg_MEM, memWr_MEM, zero_MEM;
  logic [4:0] Wsel_MEM;
  logic [1:0] WdatSel_MEM, PC_Src_MEM;
  logic [31:0] Output_Port_MEM, store_MEM, busA_MEM, branch_addr_MEM, jump_addr_MEM, npc_MEM;
  logic mem_stall, redirect, RegWr_WB, mem_err;
  logic [31:0] redirect_addr, wdat_WB, stall_cnt;
  logic [4:0] Wsel_WB;
  int n_chk = 0;
  int n_pass = 0;
  int stalls;
  mem_stage_ctrl_if #(.WORD_W(32)) dmem_bus ();
  mem_stage_ctrl #(.WORD_W(32), .TIMEOUT(64), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .valid_MEM(valid_MEM), .RegWr_MEM(RegWr_MEM), .Wsel_MEM(Wsel_MEM),
    .memtoReg_MEM(memtoReg_MEM), .memWr_MEM(memWr_MEM), .WdatSel_MEM(WdatSel_MEM),
    .PC_Src_MEM(PC_Src_MEM), .zero_MEM(zero_MEM), .Output_Port_MEM(Output_Port_MEM),
    .store_MEM(store_MEM), .busA_MEM(busA_MEM), .branch_addr_MEM(branch_addr_MEM),
    .jump_addr_MEM(jump_addr_MEM), .npc_MEM(npc_MEM), .dmem(dmem_bus), .mem_stall(mem_stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .RegWr_WB(RegWr_WB), .Wsel_WB(Wsel_WB),
    .wdat_WB(wdat_WB), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic nop();
    valid_MEM = 0; RegWr_MEM = 0; Wsel_MEM = 0; memtoReg_MEM = 0; memWr_MEM = 0;
    WdatSel_MEM = 0; PC_Src_MEM = 0; zero_MEM = 0; Output_Port_MEM = 0; store_MEM = 0;
    busA_MEM = 0; branch_addr_MEM = 0; jump_addr_MEM = 0; npc_MEM = 0;
    dmem_bus.dhit = 0; dmem_bus.dmemload = 0;
    #1;
  endtask
  task automatic load(input logic [31:0] addr, input logic [4:0] rd, input logic hit);
    nop();
    valid_MEM = 1; memtoReg_MEM = 1; RegWr_MEM = 1; Wsel_MEM = rd; WdatSel_MEM = 2'b01;
    Output_Port_MEM = addr; dmem_bus.dhit = hit;
    #1;
  endtask
  initial begin
    RST = 1;
    nop();
    step();
    step();
    load(32'h100, 5'd5, 1'b0);
    check("rst_ren", dmem_bus.dmemREN, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_regwr", RegWr_WB, 0);
    check("rst_wsel", Wsel_WB, 0);
    check("rst_wdat", wdat_WB, 0);
    check("rst_err", mem_err, 0);
    check("rst_cnt", stall_cnt, 0);
    nop();
    RST = 0;
    step();
    load(32'h100, 5'd5, 1'b1);
    dmem_bus.dmemload = 32'hDEADBEEF;
    #1;
    check("ld_ren", dmem_bus.dmemREN, 1);
    check("ld_wen", dmem_bus.dmemWEN, 0);
    check("ld_addr", dmem_bus.dmemaddr, 32'h100);
    check("ld_stall", mem_stall, 0);
    step();
    nop();
    check("ld_regwr", RegWr_WB, 1);
    check("ld_wsel", Wsel_WB, 5);
    check("ld_wdat", wdat_WB, 32'hDEADBEEF);
    check("ld_ren_off", dmem_bus.dmemREN, 0);
    step();
    check("bubble_regwr", RegWr_WB, 0);
    valid_MEM = 1; memWr_MEM = 1; Output_Port_MEM = 32'h200; store_MEM = 32'h1234;
    #1;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_bus.dhit = 1;
      #1;
      stalls += int'(mem_stall);
      check("st_wen", dmem_bus.dmemWEN, 1);
      check("st_addr", dmem_bus.dmemaddr, 32'h200);
      check("st_data", dmem_bus.dmemstore, 32'h1234);
      if (i > 0) check("st_regwr", RegWr_WB, 0);
      step();
      Output_Port_MEM = 32'h999 + i; store_MEM = 32'h5555 + i;
    end
    nop();
    check("st_stall_cycles", stalls, 3);
    check("st_cnt", stall_cnt, 3);
    check("st_regwr_end", RegWr_WB, 0);
    valid_MEM = 1; PC_Src_MEM = 2'b01; zero_MEM = 1; branch_addr_MEM = 32'h40; busA_MEM = 32'h80;
    #1;
    check("beq_red", redirect, 1);
    check("beq_addr", redirect_addr, 32'h40);
    step();
    PC_Src_MEM = 2'b11;
    #1;
    check("jr_red", redirect, 1);
    check("jr_addr", redirect_addr, 32'h80);
    step();
    PC_Src_MEM = 2'b01; zero_MEM = 0;
    #1;
    check("beq_nt_red", redirect, 0);
    check("beq_nt_addr", redirect_addr, 0);
    step();
    nop();
    valid_MEM = 1; RegWr_MEM = 1; Wsel_MEM = 31; WdatSel_MEM = 2'b10; npc_MEM = 32'h1C;
    PC_Src_MEM = 2'b10; jump_addr_MEM = 32'h300; Output_Port_MEM = 32'h77;
    #1;
    check("jal_red", redirect, 1);
    check("jal_addr", redirect_addr, 32'h300);
    check("jal_ren", dmem_bus.dmemREN | dmem_bus.dmemWEN, 0);
    check("jal_stall", mem_stall, 0);
    step();
    nop();
    check("jal_regwr", RegWr_WB, 1);
    check("jal_wsel", Wsel_WB, 31);
    check("jal_wdat", wdat_WB, 32'h1C);
    valid_MEM = 1; RegWr_MEM = 1; Wsel_MEM = 3; WdatSel_MEM = 2'b11; Output_Port_MEM = 32'hABC;
    npc_MEM = 32'h44;
    #1;
    step();
    nop();
    check("rsv_wdat", wdat_WB, 32'hABC);
    dmem_bus.dhit = 1;
    #1;
    check("stray_hit_stall", mem_stall, 0);
    check("stray_hit_ren", dmem_bus.dmemREN, 0);
    step();
    load(32'h300, 5'd9, 1'b1);
    memWr_MEM = 1;
    #1;
    check("ldst_ren", dmem_bus.dmemREN, 1);
    check("ldst_wen", dmem_bus.dmemWEN, 0);
    check("ldst_stall", mem_stall, 0);
    step();
    load(32'h400, 5'd7, 1'b0);
    stalls = 0;
    for (int i = 0; i < 200 && mem_stall; i++) begin
      stalls++;
      step();
    end
    check("to_stall_cycles", stalls, 64);
    check("to_stall_drop", mem_stall, 0);
    check("to_ren_drop", dmem_bus.dmemREN, 0);
    step();
    nop();
    check("to_err", mem_err, 1);
    check("to_regwr", RegWr_WB, 0);
    check("to_cnt", stall_cnt, 67);
    step();
    check("to_err_sticky", mem_err, 1);
    load(32'h500, 5'd8, 1'b1);
    dmem_bus.dmemload = 32'h0BAD_F00D;
    #1;
    check("to_idle_stall", mem_stall, 0);
    check("to_idle_ren", dmem_bus.dmemREN, 1);
    step();
    nop();
    check("to_idle_regwr", RegWr_WB, 1);
    check("to_idle_wdat", wdat_WB, 32'h0BAD_F00D);
    load(32'h600, 5'd4, 1'b0);
    step();
    step();
    check("rw_stall", mem_stall, 1);
    RST = 1;
    step();
    check("rw_ren", dmem_bus.dmemREN, 0);
    check("rw_stall_off", mem_stall, 0);
    check("rw_regwr", RegWr_WB, 0);
    check("rw_wsel", Wsel_WB, 0);
    check("rw_wdat", wdat_WB, 0);
    check("rw_cnt", stall_cnt, 0);
    check("rw_err", mem_err, 0);
    RST = 0;
    nop();
    step();
    check("rw_idle_ren", dmem_bus.dmemREN, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
